// File: rtl/jstk_defs_pkg.sv
// Shared PmodJSTK link definitions: frame geometry, LED command prefix,
// link state encoding and frame packing helpers used by master and responder.
package jstk_defs_pkg;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam int JSTK_FRAME_BITS  = JSTK_FRAME_BYTES * 8;
  localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } jstk_state_t;

  // Byte 0 sits in the low byte so the byte index maps straight onto a part-select.
  function automatic logic [JSTK_FRAME_BITS-1:0] jstk_pack_frame(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    return {5'b0, btn, 6'b0, y[9:8], y[7:0], 6'b0, x[9:8], x[7:0]};
  endfunction

  function automatic logic jstk_frame_bit(
    input logic [JSTK_FRAME_BITS-1:0] frame,
    input logic [2:0]                 byte_idx,
    input logic [2:0]                 bit_idx
  );
    logic [7:0] sel;
    sel = 8'h00;
    if (byte_idx < 3'(JSTK_FRAME_BYTES)) begin
      sel = frame[{byte_idx, 3'b000} +: 8];
    end
    return sel[3'd7 - bit_idx];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with registered
// rise/fall pulses aligned to the registered level output.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Everything clears low so a pin already low at reset release shows no edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~last_q;
      fall   <= ~sync_q[STAGES-1] & last_q;
    end
  end

  assign level = last_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK: serves a 5-byte position/button
// frame on MISO and decodes the master's LED command from byte 0.
import jstk_defs_pkg::*;

module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led_cmd,
  output logic       cmd_valid,
  output logic       frame_done,
  output logic       frame_err
);

  logic ss_level_unused, ss_rise, ss_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (clk),
    .clr   (clr),
    .din   (SS),
    .level (ss_level_unused),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .clr   (clr),
    .din   (SCLK),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .clr   (clr),
    .din   (MOSI),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  jstk_state_t                state;
  logic [2:0]                 bit_cnt;
  logic [2:0]                 byte_cnt;
  logic [JSTK_FRAME_BITS-1:0] frame_q;
  logic [6:0]                 rx_q;
  logic [7:0]                 rx_byte;
  logic [JSTK_FRAME_BITS-1:0] snap;

  assign rx_byte = {rx_q, mosi_level};
  assign snap    = jstk_pack_frame(x_pos, y_pos, buttons);

  // SS rise is tested first so it wins over an SCLK edge seen in the same cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      frame_q    <= '0;
      rx_q       <= '0;
      MISO       <= 1'b0;
      led_cmd    <= 2'b00;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (ss_fall) begin
            state    <= SHIFT;
            frame_q  <= snap;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_q     <= '0;
            MISO     <= snap[7];
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state      <= IDLE;
            MISO       <= 1'b0;
            frame_done <= 1'b1;
            frame_err  <= (byte_cnt < 3'(JSTK_FRAME_BYTES)) || (bit_cnt != 3'd0);
          end else if (sclk_rise) begin
            rx_q    <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt < 3'(JSTK_FRAME_BYTES)) begin
                byte_cnt <= byte_cnt + 3'd1;
              end
              if ((byte_cnt == 3'd0) && (rx_byte[7:2] == JSTK_CMD_PREFIX)) begin
                led_cmd   <= rx_byte[1:0];
                cmd_valid <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            MISO <= jstk_frame_bit(frame_q, byte_cnt, bit_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder: table-driven SPI frames,
// random frames against a byte-level reference model, and reset/speed corners.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic [2:0] buttons = '0;
  logic [1:0] led_cmd;
  logic       cmd_valid;
  logic       frame_done;
  logic       frame_err;

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .clr        (clr),
    .SS         (ss),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .MISO       (miso),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .led_cmd    (led_cmd),
    .cmd_valid  (cmd_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
    logic [7:0] cmd;
    int         nbits;
    int         half;
    int         chg_bit;
    logic [9:0] chg_x;
    bit         collide;
    int         exp_cmd;
    logic [1:0] exp_led;
    int         exp_err;
  } vec_t;

  int   total = 0;
  int   passed = 0;
  int   cmd_count = 0;
  int   done_count = 0;
  logic last_err = 1'b0;
  logic [7:0] rx_bytes [8];
  logic [1:0] model_led = 2'b00;

  // Pulse monitor sampling on the falling clock edge, away from output updates.
  always @(negedge clk) begin
    if (cmd_valid) cmd_count <= cmd_count + 1;
    if (frame_done) begin
      done_count <= done_count + 1;
      last_err   <= frame_err;
    end
  end

  // Reference frame content, straight from the byte-order table.
  function automatic logic [7:0] expByte(input logic [9:0] x, input logic [9:0] y,
                                         input logic [2:0] b, input int k);
    case (k)
      0:       return x[7:0];
      1:       return {6'b0, x[9:8]};
      2:       return y[7:0];
      3:       return {6'b0, y[9:8]};
      4:       return {5'b0, b};
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic sendBit(input logic b, input int half, output logic sampled);
    mosi = b;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    sampled = miso;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic s;
    x_pos = v.x;
    y_pos = v.y;
    buttons = v.b;
    for (int i = 0; i < 8; i++) rx_bytes[i] = 8'h00;
    @(negedge clk);
    ss = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < v.nbits; i++) begin
      if (i == v.chg_bit) x_pos = v.chg_x;
      sendBit((i < 8) ? v.cmd[7 - i] : 1'b0, v.half, s);
      rx_bytes[i / 8][7 - (i % 8)] = s;
    end
    repeat (v.half) @(negedge clk);
    ss = 1'b1;
    if (v.collide) sclk = 1'b1;
    repeat (12) @(negedge clk);
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic runFrame(input string name, input vec_t v);
    int c0, d0;
    c0 = cmd_count;
    d0 = done_count;
    applyStimulus(v);
    for (int k = 0; k < v.nbits / 8; k++)
      checkOutput($sformatf("%s miso byte%0d", name, k), rx_bytes[k], expByte(v.x, v.y, v.b, k));
    checkOutput({name, " cmd_valid pulses"}, cmd_count - c0, v.exp_cmd);
    checkOutput({name, " led_cmd"}, led_cmd, v.exp_led);
    checkOutput({name, " frame_done pulses"}, done_count - d0, 1);
    checkOutput({name, " frame_err"}, last_err, v.exp_err);
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    int   c0, d0, bad, r;
    logic s, any_miso;

    vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 8, -1, 10'h000, 1'b0, 1, 2'b11, 0};
    vecs[1] = '{10'h2A5, 10'h13C, 3'b101, 8'h43, 40, 8, -1, 10'h000, 1'b0, 0, 2'b11, 0};
    vecs[2] = '{10'h155, 10'h0AA, 3'b010, 8'h81, 40, 8, 20, 10'h3FF, 1'b0, 1, 2'b01, 0};
    vecs[3] = '{10'h3FF, 10'h0AA, 3'b010, 8'h00, 40, 8, -1, 10'h000, 1'b0, 0, 2'b01, 0};
    vecs[4] = '{10'h0F0, 10'h30F, 3'b001, 8'h82, 20, 8, -1, 10'h000, 1'b0, 1, 2'b10, 1};
    vecs[5] = '{10'h1C3, 10'h2E7, 3'b111, 8'h80, 56, 8, -1, 10'h000, 1'b0, 1, 2'b00, 0};
    vecs[6] = '{10'h2DB, 10'h124, 3'b110, 8'h43, 40, 8, -1, 10'h000, 1'b1, 0, 2'b00, 0};
    vecs[7] = '{10'h0FF, 10'h3FF, 3'b011, 8'h83, 5, 8, -1, 10'h000, 1'b0, 0, 2'b00, 1};

    repeat (3) @(negedge clk);
    checkOutput("reset miso", miso, 0);
    checkOutput("reset led_cmd", led_cmd, 0);
    checkOutput("reset cmd_valid", cmd_valid, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset frame_err", frame_err, 0);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) runFrame($sformatf("vec%0d", i), vecs[i]);
    model_led = 2'b00;

    // Reset in byte 2, then SS held low across release must draw no response.
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    d0 = done_count;
    ss = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20; i++) sendBit((i < 8) ? ((8'h83 >> (7 - i)) & 1) : 1'b0, 8, s);
    checkOutput("pre-reset led_cmd", led_cmd, 2'b11);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid reset miso", miso, 0);
    checkOutput("mid reset led_cmd", led_cmd, 0);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    c0 = cmd_count;
    any_miso = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sendBit(i < 8 ? ((8'h83 >> (7 - i)) & 1) : 1'b1, 8, s);
      any_miso = any_miso | s;
    end
    checkOutput("held SS miso quiet", any_miso, 0);
    ss = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("held SS no cmd_valid", cmd_count - c0, 0);
    checkOutput("reset no frame_done", done_count - d0, 0);
    checkOutput("held SS led_cmd", led_cmd, 0);
    runFrame("post-reset", vecs[0]);
    model_led = 2'b11;

    for (int n = 0; n < 12; n++) begin
      rv.x = 10'($urandom);
      rv.y = 10'($urandom);
      rv.b = 3'($urandom);
      rv.cmd = ($urandom_range(0, 1) == 1) ? {6'b100000, 2'($urandom)} : 8'($urandom);
      r = $urandom_range(0, 3);
      rv.nbits = (r == 0) ? 40 : (r == 1) ? 48 : (r == 2) ? 8 * $urandom_range(1, 4)
                                                          : $urandom_range(1, 45);
      rv.half = 8;
      rv.chg_bit = $urandom_range(0, 30);
      rv.chg_x = 10'($urandom);
      rv.collide = 1'b0;
      rv.exp_cmd = (rv.nbits >= 8 && rv.cmd[7:2] == 6'b100000) ? 1 : 0;
      if (rv.exp_cmd == 1) model_led = rv.cmd[1:0];
      rv.exp_led = model_led;
      rv.exp_err = (rv.nbits < 40 || rv.nbits % 8 != 0) ? 1 : 0;
      runFrame($sformatf("rand%0d", n), rv);
    end

    // Phases of 2 clk are below the limit: MISO must lag the master's sampling.
    rv = '{10'h2AA, 10'h155, 3'b010, 8'h00, 40, 2, -1, 10'h000, 1'b0, 0, model_led, 0};
    d0 = done_count;
    applyStimulus(rv);
    bad = 0;
    for (int k = 0; k < 5; k++) if (rx_bytes[k] != expByte(rv.x, rv.y, rv.b, k)) bad++;
    checkOutput("overspeed stale bits seen", (bad > 0) ? 1 : 0, 1);
    checkOutput("overspeed frame_done pulses", done_count - d0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
